// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared scan FSM states, digit count and hex-to-segment table
package seg_scan_ctrl_pkg;

    typedef enum logic {SHOW, GAP} state_t;

    localparam int NUM_DIGITS = 4;

    // Segment patterns a..g on bits 6..0, active-high, indexed by hex value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/seg_scan_ctrl_bcd_gate.sv
// bcd_gate: combinational 4-bit hex to 7-segment decoder
//   hex : nibble to decode
//   seg : segments a..g on bits 6..0, active-high
module bcd_gate
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 4-digit 7-segment scanner with tear-free shadow update
//   clk, rst : clock, synchronous active-high reset
//   load     : capture data/blank/lzs into shadow when ready
//   data     : four nibbles, [3:0] is digit 0 (rightmost)
//   blank    : per-digit force-blank
//   lzs      : leading-zero suppression enable
//   ready    : shadow free (no update pending)
//   an       : active-low digit enables
//   seg      : active-high segments a..g on bits 6..0
//   frame    : one-cycle pulse at each frame commit point
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SHOW_CYC = 1000,
    parameter int GAP_CYC  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  blank,
    input  logic        lzs,
    output logic        ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam int CW = $clog2((SHOW_CYC > GAP_CYC ? SHOW_CYC : GAP_CYC) + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   idx, idx_n;
    logic            pending;
    logic [15:0]     sh_data, act_data;
    logic [3:0]      sh_blank, act_blank;
    logic            sh_lzs, act_lzs;
    logic            commit, blk;
    logic [3:0]      an_n;
    logic [6:0]      seg_n, dec;

    bcd_gate u_dec (
        .hex (act_data[{idx, 2'b00} +: 4]),
        .seg (dec)
    );

    // Commit point: last gap cycle after digit 3, the only moment active may change
    assign commit = state == GAP && cnt == GAP_LAST && idx == IDX_LAST;
    assign ready  = ~pending;

    // A digit is zero-suppressed when it and every more-significant nibble is zero
    assign blk = act_blank[idx] |
                 (act_lzs && idx != '0 && (act_data >> {idx, 2'b00}) == 16'h0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        if (state == SHOW && cnt == SHOW_LAST) begin
            state_n = GAP;
            cnt_n   = '0;
        end else if (state == GAP && cnt == GAP_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
            idx_n   = idx + 1'b1;
        end
        an_n  = state == SHOW ? ~(4'b0001 << idx) : 4'hF;
        seg_n = (state == SHOW && !blk) ? dec : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHOW;
            cnt       <= '0;
            idx       <= '0;
            pending   <= 1'b0;
            sh_data   <= '0;
            sh_blank  <= '0;
            sh_lzs    <= 1'b0;
            act_data  <= '0;
            act_blank <= '0;
            act_lzs   <= 1'b0;
            an        <= 4'hF;
            seg       <= '0;
            frame     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            an    <= an_n;
            seg   <= seg_n;
            frame <= commit;
            if (commit && pending) begin
                act_data  <= sh_data;
                act_blank <= sh_blank;
                act_lzs   <= sh_lzs;
                pending   <= 1'b0;
            end else if (load && !pending) begin
                sh_data  <= data;
                sh_blank <= blank;
                sh_lzs   <= lzs;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYC, default 1000, clock cycles each digit is driven (>=1).
REQ-002 SHALL have parameter GAP_CYC, default 8, all-anodes-off cycles after each digit (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  request to capture data/blank/lzs into shadow; accepted only when ready=1.
REQ-006 data  input  16  four hex nibbles; [3:0]=digit 0 (rightmost) .. [15:12]=digit 3.
REQ-007 blank  input  4  per-digit force-blank, bit i = digit i.
REQ-008 lzs  input  1  leading-zero suppression enable.
REQ-009 ready  output  1  high when shadow is free; low while an update is pending.
REQ-010 an  output  4  digit enables, active-low, bit i = digit i.
REQ-011 seg  output  7  segments active-high, bit6=a .. bit0=g (hex 0 = 1111110).
REQ-012 frame  output  1  one-cycle pulse on the cycle a completed frame commits or wraps.

Function
REQ-013 FSM states: SHOW (one digit enabled), GAP (an=1111, seg=0000000).
REQ-014 SHOW lasts exactly SHOW_CYC cycles, then GAP lasts exactly GAP_CYC cycles, then digit index increments mod 4 and SHOW resumes.
REQ-015 Digit order 0,1,2,3,0...; one frame = 4*(SHOW_CYC+GAP_CYC) cycles.
REQ-016 an, seg, frame SHALL be registered; they reflect FSM state/index with exactly 1 cycle latency.
REQ-017 In SHOW for digit i, an SHALL be one-hot-low at bit i; seg SHALL be the hex decode of active nibble i unless digit i is blanked, in which case seg=0000000 and an still enables digit i.
REQ-018 Digit i blanked if active blank[i]=1, or active lzs=1, i>0, and active nibbles i..3 are all zero; digit 0 is never zero-suppressed.
REQ-019 load with ready=1 SHALL copy data/blank/lzs to shadow and set pending; ready drops the next cycle.
REQ-020 load with ready=0 SHALL be ignored (no shadow change).
REQ-021 Commit point = last GAP cycle of digit 3; if pending, shadow SHALL be copied to active and pending cleared there; ready rises the following cycle.
REQ-022 Active registers SHALL never change mid-frame (no tearing).
REQ-023 load accepted on the commit cycle itself (pending was 0) SHALL commit at the next frame's commit point.
REQ-024 frame SHALL pulse at every commit point, whether or not an update was committed.

Reset
REQ-025 rst=1 SHALL force: state=SHOW, index=0, counters=0, pending=0, shadow and active data/blank/lzs=0.
REQ-026 Outputs on the cycle after rst: an=1111, seg=0000000, frame=0, ready=1.
REQ-027 rst asserted mid-frame or with pending=1 SHALL discard the pending update; first SHOW of digit 0 starts on the first cycle rst=0.

Structure
REQ-028 Shared package SHALL hold the FSM state enum, NUM_DIGITS=4, and the 16-entry hex-to-segment constant table.
REQ-029 One sub-module SHALL be instantiated: the existing combinational 4-bit hex-to-7-segment decoder bcd_gate, shared across all digits through the index-selected nibble.
REQ-030 Counter widths SHALL be $clog2 of max(SHOW_CYC,GAP_CYC)+1.

Verification (SHOW_CYC=4, GAP_CYC=2, frame=24 cycles)
REQ-031 Reset release, no load -> digit 0 shows seg=1111110 with an=1110 for 4 cycles, then an=1111 for 2 cycles, then an=1101; frame pulse every 24 cycles.
REQ-032 load data=16'h12AF mid-frame -> current frame unchanged; next frame shows F,A,2,1 on digits 0..3 (seg 1000111,1110111,1101101,0110000).
REQ-033 Second load while ready=0 with data=16'h0000 -> ignored; 16'h12AF is still committed.
REQ-034 load data=16'h0005, lzs=1 -> digits 3,2,1 seg=0000000, digit 0 seg=1011011; with lzs=0 digits 3..1 show 1111110.
REQ-035 load blank=4'b0100 -> digit 2 seg=0000000 while an=1011; other digits decoded.
REQ-036 rst pulsed with pending=1 during digit 2 SHOW -> an=1111 next cycle, ready=1, pending update never displayed.
